// File: rtl/world_clock_pkg.sv
// Shared types and constants for the world-clock controller slice.
// Contents:
//   mode_t     - controller mode (RUN and the three SET modes)
//   constants  - counter moduli and the offset values used for mod-N decrements
//   next_mode  - mode sequence RUN -> SET_MIN -> SET_HR -> SET_ZONE -> RUN
//   min_dec / hr_dec - offset that decrements a counter by one modulo its range
package world_clock_pkg;

  typedef enum logic [1:0] {RUN, SET_MIN, SET_HR, SET_ZONE} mode_t;

  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;

  // The counters add offsets modulo 2^W. An all-ones offset is a decrement by
  // one; from zero the counter must land on MOD-1 instead of wrapping past it.
  localparam logic [5:0] MIN_DEC  = 6'd63;
  localparam logic [5:0] MIN_WRAP = 6'(MIN_MOD - 1);
  localparam logic [4:0] HR_DEC   = 5'd31;
  localparam logic [4:0] HR_WRAP  = 5'(HR_MOD - 1);

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     return SET_MIN;
      SET_MIN: return SET_HR;
      SET_HR:  return SET_ZONE;
      default: return RUN;
    endcase
  endfunction

  function automatic logic [5:0] min_dec(input logic [5:0] val);
    return (val != 6'd0) ? MIN_DEC : MIN_WRAP;
  endfunction

  function automatic logic [4:0] hr_dec(input logic [4:0] val);
    return (val != 5'd0) ? HR_DEC : HR_WRAP;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bus between the time-set controller and the minute/hour counters.
// Signals:
//   min_val, hr_val, min_cycle         - counter state/carry into the controller
//   min_en, min_offset, hr_en,
//   hr_offset                          - counter control out of the controller
//   zone_sel, mode, blink              - display/zone side outputs
// Modports: master = controller, slave = counters/display.
interface time_set_ctrl_if;
  import world_clock_pkg::*;

  logic [5:0] min_val;
  logic [4:0] hr_val;
  logic       min_cycle;
  logic       min_en;
  logic [5:0] min_offset;
  logic       hr_en;
  logic [4:0] hr_offset;
  logic [1:0] zone_sel;
  mode_t      mode;
  logic       blink;

  modport master (
    input  min_val, hr_val, min_cycle,
    output min_en, min_offset, hr_en, hr_offset, zone_sel, mode, blink
  );

  modport slave (
    output min_val, hr_val, min_cycle,
    input  min_en, min_offset, hr_en, hr_offset, zone_sel, mode, blink
  );

endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for an already-synchronized button level.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset (clears history)
//   lvl   - button level
//   rise  - high in the cycle where lvl is 1 and was 0 the cycle before
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic lvl,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_q <= 1'b0;
    else        prev_q <= lvl;
  end

  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Sequencing controller for the world-clock minute/hour counters.
// RUN: divides clk into seconds, pulses min_en once a minute, forwards the
// minute carry to the hour counter as hr_en. SET modes: turns up/down button
// edges into one-cycle offset pulses for minutes, hours or the zone index.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   btn_mode/up/down    - synchronized button levels
//   bus (master)        - counter/display bus, see time_set_ctrl_if
module time_set_ctrl
  import world_clock_pkg::*;
#(
  parameter int CLK_HZ    = 100,
  parameter int NUM_ZONES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_down,
  time_set_ctrl_if.master bus
);

  localparam int          PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2 - 1);
  localparam logic [5:0]  SEC_LAST   = 6'(MIN_MOD - 1);
  localparam logic [1:0]  ZONE_LAST  = 2'(NUM_ZONES - 1);

  logic mode_rise, up_rise, down_rise;
  logic up_ev, down_ev;

  btn_edge u_mode (.clk(clk), .reset(reset), .lvl(btn_mode), .rise(mode_rise));
  btn_edge u_up   (.clk(clk), .reset(reset), .lvl(btn_up),   .rise(up_rise));
  btn_edge u_down (.clk(clk), .reset(reset), .lvl(btn_down), .rise(down_rise));

  // A mode edge swallows up/down; simultaneous up and down cancel.
  assign up_ev   = ~mode_rise & up_rise & ~down_rise;
  assign down_ev = ~mode_rise & down_rise & ~up_rise;

  mode_t         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic          min_en_q, min_en_d;
  logic          hr_en_q, hr_en_d;
  logic [5:0]    min_off_q, min_off_d;
  logic [4:0]    hr_off_q, hr_off_d;
  logic [1:0]    zone_q, zone_d;
  logic          blink_q, blink_d;
  logic          tick;

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= RUN;
      presc_q   <= '0;
      sec_q     <= '0;
      min_en_q  <= 1'b0;
      hr_en_q   <= 1'b0;
      min_off_q <= '0;
      hr_off_q  <= '0;
      zone_q    <= '0;
      blink_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      min_en_q  <= min_en_d;
      hr_en_q   <= hr_en_d;
      min_off_q <= min_off_d;
      hr_off_q  <= hr_off_d;
      zone_q    <= zone_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    sec_d     = sec_q;
    min_en_d  = 1'b0;
    hr_en_d   = 1'b0;
    min_off_d = '0;
    hr_off_d  = '0;
    zone_d    = zone_q;
    blink_d   = blink_q;

    unique case (mode_q)
      RUN: begin
        hr_en_d = bus.min_cycle;
        blink_d = 1'b0;
        if (tick) begin
          if (sec_q == SEC_LAST) begin
            sec_d    = '0;
            min_en_d = 1'b1;
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      SET_MIN: begin
        if (up_ev)        min_off_d = 6'd1;
        else if (down_ev) min_off_d = min_dec(bus.min_val);
      end
      SET_HR: begin
        if (up_ev)        hr_off_d = 5'd1;
        else if (down_ev) hr_off_d = hr_dec(bus.hr_val);
      end
      SET_ZONE: begin
        if (up_ev)        zone_d = (zone_q == ZONE_LAST) ? 2'd0 : zone_q + 2'd1;
        else if (down_ev) zone_d = (zone_q == 2'd0) ? ZONE_LAST : zone_q - 2'd1;
      end
    endcase

    // Set modes freeze seconds at 0 and blink twice per second.
    if (mode_q != RUN) begin
      sec_d = '0;
      if (tick || presc_q == PRESC_HALF) blink_d = ~blink_q;
    end

    if (mode_rise) begin
      mode_d = next_mode(mode_q);
      sec_d  = '0;
      // Returning to RUN restarts the second count from a clean boundary.
      if (mode_q == SET_ZONE) begin
        presc_d = '0;
        blink_d = 1'b0;
      end
    end
  end

  assign bus.min_en     = min_en_q;
  assign bus.min_offset = min_off_q;
  assign bus.hr_en      = hr_en_q;
  assign bus.hr_offset  = hr_off_q;
  assign bus.zone_sel   = zone_q;
  assign bus.mode       = mode_q;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;
  import world_clock_pkg::*;

  logic clk;
  logic reset;
  logic btn_mode, btn_up, btn_down;

  time_set_ctrl_if bus();

  time_set_ctrl #(.CLK_HZ(4), .NUM_ZONES(4)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       m, u, d;
    logic [5:0] mv;
    logic [4:0] hv;
    logic       mc;
    logic       e_min_en;
    logic [5:0] e_moff;
    logic       e_hr_en;
    logic [4:0] e_hoff;
    logic [1:0] e_zone;
    mode_t      e_mode;
  } vec_t;

  vec_t tbl[31];
  vec_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, u, d, input int mv, hv, input logic mc,
                              input int moff, hoff, hen, zone, input mode_t md);
    vec_t v;
    v.m = m; v.u = u; v.d = d;
    v.mv = 6'(mv); v.hv = 5'(hv); v.mc = mc;
    v.e_min_en = 1'b0; v.e_moff = 6'(moff); v.e_hr_en = hen[0];
    v.e_hoff = 5'(hoff); v.e_zone = 2'(zone); v.e_mode = md;
    return v;
  endfunction

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_min_en"}, int'(bus.min_en), 0);
    chk({tag, "_moff"},   int'(bus.min_offset), 0);
    chk({tag, "_hr_en"},  int'(bus.hr_en), 0);
    chk({tag, "_hoff"},   int'(bus.hr_offset), 0);
    chk({tag, "_zone"},   int'(bus.zone_sel), 0);
    chk({tag, "_mode"},   int'(bus.mode), int'(RUN));
    chk({tag, "_blink"},  int'(bus.blink), 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    btn_mode = 0; btn_up = 0; btn_down = 0;
    bus.min_cycle = 0; bus.min_val = 0; bus.hr_val = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  int pulses, pos;
  vec_t e;
  logic [5:0] blink_exp [5];

  initial begin
    reset = 1'b1;
    btn_mode = 0; btn_up = 0; btn_down = 0;
    bus.min_val = 0; bus.hr_val = 0; bus.min_cycle = 0;

    // Async reset: outputs clear without a clock edge.
    #2 reset = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // One minute of RUN at CLK_HZ=4: min_en exactly once, after edge 240.
    pulses = 0; pos = 0;
    for (int k = 1; k <= 245; k++) begin
      edge1();
      if (bus.min_en) begin
        pulses++;
        pos = k;
      end
    end
    chk("minute_pulse_count", pulses, 1);
    chk("minute_pulse_cycle", pos, 240);

    //         m  u  d  mv hv mc  moff hoff hen zone mode
    tbl[0]  = mk(0, 0, 0, 0, 0, 1,  0,  0, 1, 0, RUN);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, RUN);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0,  0,  0, 0, 0, SET_MIN);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, SET_MIN);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1,  0,  0, 0, 0, SET_MIN);
    tbl[5]  = mk(0, 0, 1, 0, 0, 0, 59,  0, 0, 0, SET_MIN);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, SET_MIN);
    tbl[7]  = mk(0, 0, 1, 5, 0, 0, 63,  0, 0, 0, SET_MIN);
    tbl[8]  = mk(0, 0, 0, 5, 0, 0,  0,  0, 0, 0, SET_MIN);
    tbl[9]  = mk(0, 1, 0, 5, 0, 0,  1,  0, 0, 0, SET_MIN);
    tbl[10] = mk(0, 0, 0, 5, 0, 0,  0,  0, 0, 0, SET_MIN);
    tbl[11] = mk(0, 1, 1, 5, 0, 0,  0,  0, 0, 0, SET_MIN);
    tbl[12] = mk(0, 0, 0, 5, 0, 0,  0,  0, 0, 0, SET_MIN);
    tbl[13] = mk(1, 0, 1, 5, 0, 0,  0,  0, 0, 0, SET_HR);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, SET_HR);
    tbl[15] = mk(0, 0, 1, 0, 0, 0,  0, 23, 0, 0, SET_HR);
    tbl[16] = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, SET_HR);
    tbl[17] = mk(0, 0, 1, 0, 7, 0,  0, 31, 0, 0, SET_HR);
    tbl[18] = mk(0, 0, 0, 0, 7, 0,  0,  0, 0, 0, SET_HR);
    tbl[19] = mk(0, 1, 0, 0, 7, 0,  0,  1, 0, 0, SET_HR);
    tbl[20] = mk(0, 0, 0, 0, 7, 0,  0,  0, 0, 0, SET_HR);
    tbl[21] = mk(1, 0, 0, 0, 0, 0,  0,  0, 0, 0, SET_ZONE);
    tbl[22] = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, SET_ZONE);
    tbl[23] = mk(0, 0, 1, 0, 0, 0,  0,  0, 0, 3, SET_ZONE);
    tbl[24] = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 3, SET_ZONE);
    tbl[25] = mk(0, 1, 0, 0, 0, 0,  0,  0, 0, 0, SET_ZONE);
    tbl[26] = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 0, SET_ZONE);
    tbl[27] = mk(0, 1, 0, 0, 0, 0,  0,  0, 0, 1, SET_ZONE);
    tbl[28] = mk(0, 0, 0, 0, 0, 0,  0,  0, 0, 1, SET_ZONE);
    tbl[29] = mk(1, 0, 0, 0, 0, 0,  0,  0, 0, 1, RUN);
    tbl[30] = mk(0, 0, 0, 0, 0, 1,  0,  0, 1, 1, RUN);

    for (int i = 0; i < 31; i++) begin
      btn_mode = tbl[i].m; btn_up = tbl[i].u; btn_down = tbl[i].d;
      bus.min_val = tbl[i].mv; bus.hr_val = tbl[i].hv; bus.min_cycle = tbl[i].mc;
      sb.push_back(tbl[i]);
      edge1();
      e = sb.pop_front();
      chk($sformatf("v%0d_min_en", i), int'(bus.min_en), int'(e.e_min_en));
      chk($sformatf("v%0d_moff", i),   int'(bus.min_offset), int'(e.e_moff));
      chk($sformatf("v%0d_hr_en", i),  int'(bus.hr_en), int'(e.e_hr_en));
      chk($sformatf("v%0d_hoff", i),   int'(bus.hr_offset), int'(e.e_hoff));
      chk($sformatf("v%0d_zone", i),   int'(bus.zone_sel), int'(e.e_zone));
      chk($sformatf("v%0d_mode", i),   int'(bus.mode), int'(e.e_mode));
    end
    btn_mode = 0; btn_up = 0; btn_down = 0; bus.min_cycle = 0;

    // Blink in SET_MIN: toggles at presc 1 and 3 once the mode has changed.
    do_reset();
    btn_mode = 1'b1;
    edge1();
    chk("blink_enter_mode", int'(bus.mode), int'(SET_MIN));
    chk("blink_enter", int'(bus.blink), 0);
    btn_mode = 1'b0;
    blink_exp[0] = 1; blink_exp[1] = 1; blink_exp[2] = 0;
    blink_exp[3] = 0; blink_exp[4] = 1;
    for (int k = 0; k < 5; k++) begin
      edge1();
      chk($sformatf("blink_%0d", k), int'(bus.blink), int'(blink_exp[k][0]));
    end

    // Reset in the middle of an offset pulse clears everything at once.
    btn_up = 1'b1;
    edge1();
    chk("midrst_pulse", int'(bus.min_offset), 1);
    reset = 1'b0;
    #1 chk_all_zero("midrst");
    btn_up = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    edge1();
    chk("midrst_after_moff", int'(bus.min_offset), 0);
    chk("midrst_after_mode", int'(bus.mode), int'(RUN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
